// File: rtl/gc.sv
// Global urisc core configuration constants shared by the core and its wrappers.
// Latency: not applicable (constants only).
// Backpressure: not applicable.
package gc;
   localparam int WORD_SIZE = 8;
endpackage

// File: rtl/urisc_run_ctrl_if.sv
// Signal bundle between the run controller and the board/bench side.
// Latency: none (wires only); master = controller, slave = stimulus/monitor side.
// Backpressure: none; start is level-sampled, all status outputs are registered.
//
// Ports: start (request), led (observed core output), core_rst, busy, done,
//        pass, timeout, cyc_count, led_last (controller status).
interface urisc_run_ctrl_if #(
   parameter int WORD_SIZE = 8,
   parameter int CNT_W     = 16
);
   logic                 start;
   logic [WORD_SIZE-1:0] led;
   logic                 core_rst;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic                 timeout;
   logic [CNT_W-1:0]     cyc_count;
   logic [WORD_SIZE-1:0] led_last;

   modport master (
      input  start, led,
      output core_rst, busy, done, pass, timeout, cyc_count, led_last
   );

   modport slave (
      output start, led,
      input  core_rst, busy, done, pass, timeout, cyc_count, led_last
   );
endinterface

// File: rtl/urisc_run_ctrl.sv
// Run controller: free-run (PRE), core reset pulse (RESET), bounded RUN window watching led.
// Latency: start -> first RUN cycle = PRE_CYCLES + max(RST_CYCLES,1) + 1 cycles; outputs registered.
// Backpressure: none; start is ignored outside IDLE (and in DONE unless restart is enabled).
//
// Ports: clk, rst (async active-high), bus (urisc_run_ctrl_if.master):
//   start/led in; core_rst, busy, done, pass, timeout, cyc_count, led_last out.
// Build option: define URISC_RUN_RESTART_EN to let start in DONE launch a new sequence.
module urisc_run_ctrl #(
   parameter int                   WORD_SIZE  = gc::WORD_SIZE,
   parameter int                   CNT_W      = 16,
   parameter int                   PRE_CYCLES = 5,
   parameter int                   RST_CYCLES = 2,
   parameter int                   RUN_CYCLES = 5,
   parameter logic [WORD_SIZE-1:0] EXPECT     = '0,
   parameter int                   STABLE     = 1
) (
   input  logic             clk,
   input  logic             rst,
   urisc_run_ctrl_if.master bus
);

   // A zero/negative reset length still gives the core one reset cycle.
   localparam int RST_EFF = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
   localparam int PRE_EFF = (PRE_CYCLES < 0) ? 0 : PRE_CYCLES;
   localparam int SEQ_MAX = (PRE_EFF > RST_EFF) ? PRE_EFF : RST_EFF;
   // The shared down-counter only ever holds (length - 1).
   localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
   localparam int STB_EFF = (STABLE < 1) ? 1 : STABLE;
   localparam int MATCH_W = (STB_EFF > 1) ? $clog2(STB_EFF + 1) : 1;

   localparam logic [SEQ_W-1:0]   PRE_LOAD   = SEQ_W'(PRE_EFF - 1);
   localparam logic [SEQ_W-1:0]   RST_LOAD   = SEQ_W'(RST_EFF - 1);
   localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(RUN_CYCLES - 1);
   localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(STB_EFF);

   generate
      if (RUN_CYCLES < 1) begin : g_bad_run_min
         $error("urisc_run_ctrl: RUN_CYCLES must be at least 1");
      end
      if (longint'(RUN_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_run_max
         $error("urisc_run_ctrl: RUN_CYCLES must be below 2**CNT_W");
      end
      if (STABLE < 1) begin : g_bad_stable
         $error("urisc_run_ctrl: STABLE must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_RESET = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [SEQ_W-1:0]     seq_q, seq_d;
   logic [CNT_W-1:0]     cyc_q, cyc_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic                 pass_q, pass_d;
   logic                 timeout_q, timeout_d;
   logic [WORD_SIZE-1:0] led_last_q, led_last_d;
   logic                 core_rst_q, core_rst_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 start_seq;
   logic                 led_hit;
   logic                 pass_hit;
   logic                 timeout_hit;

   assign led_hit = (bus.led == EXPECT);

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      cyc_d       = cyc_q;
      match_d     = match_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      led_last_d  = led_last_q;
      start_seq   = 1'b0;
      pass_hit    = 1'b0;
      timeout_hit = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               start_seq = 1'b1;
            end
         end
         S_PRE: begin
            if (seq_q == '0) begin
               state_d = S_RESET;
               seq_d   = RST_LOAD;
            end else begin
               seq_d = seq_q - 1'b1;
            end
         end
         S_RESET: begin
            if (seq_q == '0) begin
               state_d = S_RUN;
            end else begin
               seq_d = seq_q - 1'b1;
            end
         end
         S_RUN: begin
            // Saturating run-length of consecutive matches, including this cycle.
            if (led_hit) begin
               match_d = (match_q == MATCH_FULL) ? match_q : match_q + 1'b1;
            end else begin
               match_d = '0;
            end
            pass_hit    = (match_d == MATCH_FULL);
            timeout_hit = (cyc_q == CYC_LAST);
            // Pass is checked first so a final-cycle success never reads as timeout.
            if (pass_hit) begin
               state_d    = S_DONE;
               pass_d     = 1'b1;
               led_last_d = bus.led;
            end else if (timeout_hit) begin
               state_d    = S_DONE;
               timeout_d  = 1'b1;
               led_last_d = bus.led;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_DONE: begin
`ifdef URISC_RUN_RESTART_EN
            if (bus.start) begin
               start_seq = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               cyc_d     = '0;
               match_d   = '0;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_seq) begin
         if (PRE_EFF == 0) begin
            state_d = S_RESET;
            seq_d   = RST_LOAD;
         end else begin
            state_d = S_PRE;
            seq_d   = PRE_LOAD;
         end
      end

      // Status flops follow the next state so they line up with the state register.
      core_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
      busy_d     = (state_d == S_PRE) || (state_d == S_RESET) || (state_d == S_RUN);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         seq_q      <= '0;
         cyc_q      <= '0;
         match_q    <= '0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         led_last_q <= '0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         cyc_q      <= cyc_d;
         match_q    <= match_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         led_last_q <= led_last_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.core_rst  = core_rst_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.timeout   = timeout_q;
   assign bus.cyc_count = cyc_q;
   assign bus.led_last  = led_last_q;

endmodule

// File: tb/tb_urisc_run_ctrl.sv
// Bench for urisc_run_ctrl: four parameterisations driven from one clock.
// Latency: n/a; inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a; expected results are queued at launch and popped when done is seen.
module tb_urisc_run_ctrl;

   logic clk;
   logic rst0;
   logic rst_o;

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic        core_rst;
      logic        busy;
      logic        done;
      logic        pass;
      logic        timeout;
      logic [15:0] cyc;
      logic [7:0]  led_last;
   } obs_t;

   typedef struct {
      logic        pass_f;
      logic        timeout_f;
      logic [15:0] cyc;
      logic [7:0]  led_last;
      int          k_done;
   } exp_t;

   localparam obs_t OBS_RST = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0};

   exp_t       sb[$];
   obs_t       tr[64];
   logic [7:0] led_k[64];

   urisc_run_ctrl_if #(.WORD_SIZE(8), .CNT_W(16)) if0 ();
   urisc_run_ctrl_if #(.WORD_SIZE(8), .CNT_W(16)) if1 ();
   urisc_run_ctrl_if #(.WORD_SIZE(8), .CNT_W(16)) if2 ();
   urisc_run_ctrl_if #(.WORD_SIZE(8), .CNT_W(16)) if3 ();

   urisc_run_ctrl #(.WORD_SIZE(8)) u0 (.clk(clk), .rst(rst0), .bus(if0.master));

   urisc_run_ctrl #(.WORD_SIZE(8), .RUN_CYCLES(10), .EXPECT(8'hA5), .STABLE(3))
      u1 (.clk(clk), .rst(rst_o), .bus(if1.master));

   urisc_run_ctrl #(.WORD_SIZE(8), .RUN_CYCLES(4), .EXPECT(8'h5A), .STABLE(1))
      u2 (.clk(clk), .rst(rst_o), .bus(if2.master));

   urisc_run_ctrl #(.WORD_SIZE(8), .PRE_CYCLES(0), .RST_CYCLES(0), .EXPECT(8'h3C))
      u3 (.clk(clk), .rst(rst_o), .bus(if3.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic get_obs(input int id, output obs_t o);
      case (id)
         0: o = {if0.core_rst, if0.busy, if0.done, if0.pass, if0.timeout, if0.cyc_count, if0.led_last};
         1: o = {if1.core_rst, if1.busy, if1.done, if1.pass, if1.timeout, if1.cyc_count, if1.led_last};
         2: o = {if2.core_rst, if2.busy, if2.done, if2.pass, if2.timeout, if2.cyc_count, if2.led_last};
         3: o = {if3.core_rst, if3.busy, if3.done, if3.pass, if3.timeout, if3.cyc_count, if3.led_last};
         default: o = '0;
      endcase
   endtask

   task automatic set_in(input int id, input logic s, input logic [7:0] l);
      case (id)
         0: begin if0.start = s; if0.led = l; end
         1: begin if1.start = s; if1.led = l; end
         2: begin if2.start = s; if2.led = l; end
         3: begin if3.start = s; if3.led = l; end
         default: ;
      endcase
   endtask

   // Raise start for exactly one sampling edge; returns on the following falling edge (k = 0).
   task automatic start_pulse(input int id, input logic [7:0] l);
      set_in(id, 1'b1, l);
      @(negedge clk);
   endtask

   // Records n cycles of outputs into tr[] while driving led_k[], then extracts timing markers.
   // A marker that never appears stays at -1, so every wait here is bounded by n.
   task automatic measure(input int id, input int n, output int k_rise, output int k_fall,
                          output int run_n, output int k_done);
      k_rise = -1; k_fall = -1; run_n = 0; k_done = -1;
      for (int k = 0; k < n; k++) begin
         get_obs(id, tr[k]);
         set_in(id, 1'b0, led_k[k]);
         @(negedge clk);
      end
      for (int k = 0; k < n; k++) begin
         if (k_rise < 0 && tr[k].core_rst) k_rise = k;
         if (k_rise >= 0 && k_fall < 0 && !tr[k].core_rst) k_fall = k;
         if (k_done < 0 && tr[k].done) k_done = k;
      end
      for (int k = 0; k < n; k++) begin
         if (k_fall >= 0 && k >= k_fall && tr[k].busy && !tr[k].core_rst) run_n++;
      end
   endtask

   task automatic test_reset();
      obs_t o;
      for (int id = 0; id < 4; id++) begin
         get_obs(id, o);
         checks++;
         if (o !== OBS_RST) $display("FAIL reset_u%0d: got %h want %h", id, o, OBS_RST);
         else passes++;
      end
   endtask

   // Defaults, led stuck at 3: PRE 5, RESET 2, RUN 5, then timeout with cyc_count 4.
   task automatic test_timeout(input string tag);
      int kr, kf, rn, kd;
      exp_t e;
      sb.push_back('{1'b0, 1'b1, 16'd4, 8'h03, 12});
      for (int k = 0; k < 64; k++) led_k[k] = 8'h03;
      start_pulse(0, 8'h03);
      measure(0, 20, kr, kf, rn, kd);
      e = sb.pop_front();
      checks++; if (kr !== 5) $display("FAIL %s pre_len: got %0d want 5", tag, kr); else passes++;
      checks++; if (kf - kr !== 2) $display("FAIL %s rst_len: got %0d want 2", tag, kf - kr); else passes++;
      checks++; if (rn !== 5) $display("FAIL %s run_len: got %0d want 5", tag, rn); else passes++;
      checks++; if (tr[7].cyc !== 16'd0) $display("FAIL %s first_run_cyc: got %0d want 0", tag, tr[7].cyc); else passes++;
      checks++;
      if (kd !== e.k_done) $display("FAIL %s done_cycle: got %0d want %0d", tag, kd, e.k_done);
      else passes++;
      if (kd >= 0) begin
         checks++; if (tr[kd].pass !== e.pass_f) $display("FAIL %s pass: got %b want %b", tag, tr[kd].pass, e.pass_f); else passes++;
         checks++; if (tr[kd].timeout !== e.timeout_f) $display("FAIL %s timeout: got %b want %b", tag, tr[kd].timeout, e.timeout_f); else passes++;
         checks++; if (tr[kd].cyc !== e.cyc) $display("FAIL %s cyc_count: got %0d want %0d", tag, tr[kd].cyc, e.cyc); else passes++;
         checks++; if (tr[kd].led_last !== e.led_last) $display("FAIL %s led_last: got %h want %h", tag, tr[kd].led_last, e.led_last); else passes++;
      end
   endtask

   task automatic test_done_restart();
      int kr, kf, rn, kd;
      exp_t e;
`ifdef URISC_RUN_RESTART_EN
      sb.push_back('{1'b0, 1'b1, 16'd4, 8'h03, 12});
      for (int k = 0; k < 64; k++) led_k[k] = 8'h03;
      start_pulse(0, 8'h03);
      measure(0, 20, kr, kf, rn, kd);
      e = sb.pop_front();
      checks++;
      if ({tr[0].done, tr[0].pass, tr[0].timeout} !== 3'b000)
         $display("FAIL restart_clear_flags: got %b want 000", {tr[0].done, tr[0].pass, tr[0].timeout});
      else passes++;
      checks++; if (tr[0].cyc !== 16'd0) $display("FAIL restart_clear_cyc: got %0d want 0", tr[0].cyc); else passes++;
      checks++; if (tr[0].led_last !== 8'h03) $display("FAIL restart_led_last_hold: got %h want 03", tr[0].led_last); else passes++;
      checks++; if (kr !== 5 || kf !== 7) $display("FAIL restart_core_rst: got %0d..%0d want 5..7", kr, kf); else passes++;
      checks++;
      if (kd !== e.k_done) $display("FAIL restart_done_cycle: got %0d want %0d", kd, e.k_done);
      else passes++;
      if (kd >= 0) begin
         checks++; if (tr[kd].timeout !== e.timeout_f) $display("FAIL restart_timeout: got %b want %b", tr[kd].timeout, e.timeout_f); else passes++;
      end
`else
      int bad;
      for (int k = 0; k < 64; k++) led_k[k] = 8'h03;
      start_pulse(0, 8'h03);
      measure(0, 8, kr, kf, rn, kd);
      bad = 0;
      for (int k = 0; k < 8; k++) if (!tr[k].done || tr[k].core_rst || tr[k].busy) bad++;
      checks++; if (bad !== 0) $display("FAIL done_sticky: got %0d bad cycles want 0", bad); else passes++;
      checks++; if (kd !== 0) $display("FAIL done_sticky_first: got %0d want 0", kd); else passes++;
      checks++;
      if ({tr[7].timeout, tr[7].cyc} !== {1'b1, 16'd4})
         $display("FAIL done_sticky_result: got %b/%0d want 1/4", tr[7].timeout, tr[7].cyc);
      else passes++;
      if (kr + kf + rn < -3) $display("note: unexpected markers");
      e.k_done = 0;
      if (sb.size() != 0) e = sb.pop_front();
`endif
   endtask

   task automatic test_mid_run_reset();
      obs_t o;
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      @(negedge clk);
      start_pulse(0, 8'h03);
      for (int k = 0; k < 9; k++) begin
         set_in(0, 1'b0, 8'h03);
         @(negedge clk);
      end
      get_obs(0, o);
      checks++;
      if ({o.busy, o.core_rst, o.cyc} !== {1'b1, 1'b0, 16'd2})
         $display("FAIL midrst_in_run2: got %b/%b/%0d want 1/0/2", o.busy, o.core_rst, o.cyc);
      else passes++;
      rst0 = 1'b1;
      #1;
      get_obs(0, o);
      checks++; if (o !== OBS_RST) $display("FAIL midrst_async: got %h want %h", o, OBS_RST); else passes++;
      @(negedge clk);
      rst0 = 1'b0;
      @(negedge clk);
      get_obs(0, o);
      checks++; if (o !== OBS_RST) $display("FAIL midrst_idle: got %h want %h", o, OBS_RST); else passes++;
      test_timeout("replay");
   endtask

   // EXPECT A5, STABLE 3, RUN 10; matches on RUN cycles 2,3,5,6,7 -> pass on cycle 7.
   task automatic test_stable_pass();
      int kr, kf, rn, kd;
      exp_t e;
      sb.push_back('{1'b1, 1'b0, 16'd7, 8'hA5, 15});
      for (int k = 0; k < 64; k++) led_k[k] = 8'h00;
      led_k[9] = 8'hA5; led_k[10] = 8'hA5; led_k[12] = 8'hA5; led_k[13] = 8'hA5; led_k[14] = 8'hA5;
      start_pulse(1, 8'h00);
      measure(1, 24, kr, kf, rn, kd);
      e = sb.pop_front();
      checks++; if (kr !== 5 || kf !== 7) $display("FAIL stable core_rst: got %0d..%0d want 5..7", kr, kf); else passes++;
      checks++; if (rn !== 8) $display("FAIL stable run_len: got %0d want 8", rn); else passes++;
      checks++;
      if (kd !== e.k_done) $display("FAIL stable done_cycle: got %0d want %0d", kd, e.k_done);
      else passes++;
      if (kd >= 0) begin
         checks++; if (tr[kd].pass !== e.pass_f) $display("FAIL stable pass: got %b want %b", tr[kd].pass, e.pass_f); else passes++;
         checks++; if (tr[kd].timeout !== e.timeout_f) $display("FAIL stable timeout: got %b want %b", tr[kd].timeout, e.timeout_f); else passes++;
         checks++; if (tr[kd].cyc !== e.cyc) $display("FAIL stable cyc_count: got %0d want %0d", tr[kd].cyc, e.cyc); else passes++;
         checks++; if (tr[kd].led_last !== e.led_last) $display("FAIL stable led_last: got %h want %h", tr[kd].led_last, e.led_last); else passes++;
      end
   endtask

   // STABLE 1, RUN 4; the only match lands on the final RUN cycle, so pass wins over timeout.
   task automatic test_pass_wins();
      int kr, kf, rn, kd;
      exp_t e;
      sb.push_back('{1'b1, 1'b0, 16'd3, 8'h5A, 11});
      for (int k = 0; k < 64; k++) led_k[k] = 8'h11;
      led_k[10] = 8'h5A;
      start_pulse(2, 8'h11);
      measure(2, 18, kr, kf, rn, kd);
      e = sb.pop_front();
      checks++; if (rn !== 4) $display("FAIL passwins run_len: got %0d want 4", rn); else passes++;
      checks++;
      if (kd !== e.k_done) $display("FAIL passwins done_cycle: got %0d want %0d", kd, e.k_done);
      else passes++;
      if (kd >= 0) begin
         checks++; if (tr[kd].pass !== e.pass_f) $display("FAIL passwins pass: got %b want %b", tr[kd].pass, e.pass_f); else passes++;
         checks++; if (tr[kd].timeout !== e.timeout_f) $display("FAIL passwins timeout: got %b want %b", tr[kd].timeout, e.timeout_f); else passes++;
         checks++; if (tr[kd].cyc !== e.cyc) $display("FAIL passwins cyc_count: got %0d want %0d", tr[kd].cyc, e.cyc); else passes++;
         checks++; if (tr[kd].led_last !== e.led_last) $display("FAIL passwins led_last: got %h want %h", tr[kd].led_last, e.led_last); else passes++;
      end
   endtask

   // PRE 0, RST 0: one RESET cycle straight from IDLE, RUN two cycles after start; fastest pass.
   task automatic test_zero_pre_rst();
      int kr, kf, rn, kd;
      exp_t e;
      obs_t o;
      get_obs(3, o);
      checks++; if (o.core_rst !== 1'b1) $display("FAIL zero idle_core_rst: got %b want 1", o.core_rst); else passes++;
      sb.push_back('{1'b1, 1'b0, 16'd0, 8'h3C, 2});
      for (int k = 0; k < 64; k++) led_k[k] = 8'h00;
      led_k[1] = 8'h3C;
      start_pulse(3, 8'h00);
      measure(3, 8, kr, kf, rn, kd);
      e = sb.pop_front();
      checks++;
      if ({tr[0].core_rst, tr[0].busy} !== 2'b11)
         $display("FAIL zero reset_cycle: got %b want 11", {tr[0].core_rst, tr[0].busy});
      else passes++;
      checks++; if (kr !== 0 || kf !== 1) $display("FAIL zero rst_len: got %0d..%0d want 0..1", kr, kf); else passes++;
      checks++;
      if ({tr[1].core_rst, tr[1].busy, tr[1].cyc} !== {1'b0, 1'b1, 16'd0})
         $display("FAIL zero run_start: got %b/%b/%0d want 0/1/0", tr[1].core_rst, tr[1].busy, tr[1].cyc);
      else passes++;
      checks++;
      if (kd !== e.k_done) $display("FAIL zero done_cycle: got %0d want %0d", kd, e.k_done);
      else passes++;
      if (kd >= 0) begin
         checks++; if (tr[kd].pass !== e.pass_f) $display("FAIL zero pass: got %b want %b", tr[kd].pass, e.pass_f); else passes++;
         checks++; if (tr[kd].timeout !== e.timeout_f) $display("FAIL zero timeout: got %b want %b", tr[kd].timeout, e.timeout_f); else passes++;
         checks++; if (tr[kd].led_last !== e.led_last) $display("FAIL zero led_last: got %h want %h", tr[kd].led_last, e.led_last); else passes++;
      end
      checks++; if (rn !== 1) $display("FAIL zero run_len: got %0d want 1", rn); else passes++;
   endtask

   initial begin
      rst0  = 1'b1;
      rst_o = 1'b1;
      for (int id = 0; id < 4; id++) set_in(id, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      test_reset();
      rst0  = 1'b0;
      rst_o = 1'b0;
      repeat (2) @(negedge clk);
      test_timeout("timeout");
      test_done_restart();
      test_mid_run_reset();
      test_stable_pass();
      test_pass_wins();
      test_zero_pre_rst();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
